// File: rtl/dcfeb_readout_pkg.sv
// Shared constants and write-side state encoding for the DCFEB readout path.
// The reader documentation refers to the same state names.
package dcfeb_readout_pkg;

  localparam int NCHIP     = 5;
  localparam int NCHAN     = 16;
  localparam int SAMPLE_W  = 12;
  localparam int L1A_W     = 12;
  localparam int L1A_NUM_W = 2 * L1A_W;
  localparam int CHIP_W    = 3;
  localparam int CHAN_W    = 4;
  localparam int CNT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_HDR2  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } wr_state_t;

endpackage

// File: rtl/sample_block_writer_if.sv
// Handshake and FIFO-write bundle between the sample block writer and its neighbours.
// master = writer side, slave = trigger/reader/FIFO side.
interface sample_block_writer_if;
  import dcfeb_readout_pkg::*;

  logic                 JTAG_MODE;
  logic                 L1A_MATCH;
  logic [L1A_NUM_W-1:0] L1A_NUM;
  logic                 BLK_DONE;
  logic                 L1A_WR_EN;
  logic [L1A_W-1:0]     L1A_WDATA;
  logic                 WREN;
  logic [CHIP_W-1:0]    CHIP;
  logic [CHAN_W-1:0]    CHAN;
  logic                 RDY;
  logic                 OVFL;
  logic [CNT_W-1:0]     BLK_CNT;

  modport master (
    input  JTAG_MODE, L1A_MATCH, L1A_NUM, BLK_DONE,
    output L1A_WR_EN, L1A_WDATA, WREN, CHIP, CHAN, RDY, OVFL, BLK_CNT
  );

  modport slave (
    output JTAG_MODE, L1A_MATCH, L1A_NUM, BLK_DONE,
    input  L1A_WR_EN, L1A_WDATA, WREN, CHIP, CHAN, RDY, OVFL, BLK_CNT
  );

endinterface

// File: rtl/blk_counter.sv
// Up/down count of complete buffered blocks; never drops below zero or rises above MAX_BLK.
// rdy is registered from the next count so it changes on the same edge as cnt.
module blk_counter #(
  parameter int MAX_BLK = 4,
  parameter int CNT_W   = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             rdy
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             rdy_reg;

  // A simultaneous completion and consumption cancel out.
  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec) begin
      if (cnt_reg < CNT_W'(MAX_BLK))
        cnt_next = cnt_reg + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_reg != '0)
        cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
      rdy_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      rdy_reg <= (cnt_next != '0);
    end
  end

  assign cnt = cnt_reg;
  assign rdy = rdy_reg;

endmodule

// File: rtl/sample_block_writer.sv
// DCFEB sample-buffer write controller: per accepted L1A match, two L1A header words
// then NCHIP*NCHAN sample writes (chip inner, channel outer), then the block is counted.
module sample_block_writer #(
  parameter int NCHIP   = dcfeb_readout_pkg::NCHIP,
  parameter int NCHAN   = dcfeb_readout_pkg::NCHAN,
  parameter int MAX_BLK = 4
) (
  input logic                   CLK,
  input logic                   RST,
  sample_block_writer_if.master bus
);
  import dcfeb_readout_pkg::*;

  localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(NCHIP - 1);
  localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(NCHAN - 1);

  wr_state_t          state_reg, state_next;
  logic [L1A_W-1:0]   l1a_hi_reg, l1a_hi_next;
  logic               l1a_wr_en_reg, l1a_wr_en_next;
  logic [L1A_W-1:0]   l1a_wdata_reg, l1a_wdata_next;
  logic               wren_reg, wren_next;
  logic [CHIP_W-1:0]  chip_reg, chip_next;
  logic [CHAN_W-1:0]  chan_reg, chan_next;
  logic               ovfl_reg, ovfl_next;

  logic [CNT_W-1:0]   blk_cnt;
  logic               rdy;
  logic               accept;
  logic               block_done;

  assign accept     = (state_reg == ST_IDLE) && !bus.JTAG_MODE && (blk_cnt < CNT_W'(MAX_BLK));
  assign block_done = (state_reg == ST_DONE);

  // Outputs are registered from the next state, so each state's outputs are
  // visible during the cycle the state register holds that state.
  always_comb begin
    state_next     = state_reg;
    l1a_hi_next    = l1a_hi_reg;
    l1a_wr_en_next = 1'b0;
    l1a_wdata_next = l1a_wdata_reg;
    wren_next      = 1'b0;
    chip_next      = chip_reg;
    chan_next      = chan_reg;
    ovfl_next      = bus.L1A_MATCH && !accept;

    case (state_reg)
      ST_IDLE: begin
        if (bus.L1A_MATCH && accept) begin
          // Low half goes out immediately; only the high half needs holding.
          state_next     = ST_HDR1;
          l1a_hi_next    = bus.L1A_NUM[L1A_NUM_W-1:L1A_W];
          l1a_wr_en_next = 1'b1;
          l1a_wdata_next = bus.L1A_NUM[L1A_W-1:0];
        end
      end
      ST_HDR1: begin
        state_next     = ST_HDR2;
        l1a_wr_en_next = 1'b1;
        l1a_wdata_next = l1a_hi_reg;
      end
      ST_HDR2: begin
        state_next = ST_WRITE;
        wren_next  = 1'b1;
        chip_next  = '0;
        chan_next  = '0;
      end
      ST_WRITE: begin
        if (chip_reg == CHIP_LAST && chan_reg == CHAN_LAST) begin
          state_next = ST_DONE;
        end else if (chip_reg == CHIP_LAST) begin
          wren_next = 1'b1;
          chip_next = '0;
          chan_next = chan_reg + 1'b1;
        end else begin
          wren_next = 1'b1;
          chip_next = chip_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      l1a_hi_reg    <= '0;
      l1a_wr_en_reg <= 1'b0;
      l1a_wdata_reg <= '0;
      wren_reg      <= 1'b0;
      chip_reg      <= '0;
      chan_reg      <= '0;
      ovfl_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      l1a_hi_reg    <= l1a_hi_next;
      l1a_wr_en_reg <= l1a_wr_en_next;
      l1a_wdata_reg <= l1a_wdata_next;
      wren_reg      <= wren_next;
      chip_reg      <= chip_next;
      chan_reg      <= chan_next;
      ovfl_reg      <= ovfl_next;
    end
  end

  blk_counter #(
    .MAX_BLK (MAX_BLK),
    .CNT_W   (CNT_W)
  ) u_blk_counter (
    .CLK (CLK),
    .RST (RST),
    .inc (block_done),
    .dec (bus.BLK_DONE),
    .cnt (blk_cnt),
    .rdy (rdy)
  );

  assign bus.L1A_WR_EN = l1a_wr_en_reg;
  assign bus.L1A_WDATA = l1a_wdata_reg;
  assign bus.WREN      = wren_reg;
  assign bus.CHIP      = chip_reg;
  assign bus.CHAN      = chan_reg;
  assign bus.OVFL      = ovfl_reg;
  assign bus.BLK_CNT   = blk_cnt;
  assign bus.RDY       = rdy;

endmodule

// File: tb/tb_sample_block_writer.sv
// Directed bench for sample_block_writer: header words, write order, block counting,
// drops (busy/full/JTAG), simultaneous count events and reset mid-block.
module tb_sample_block_writer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sample_block_writer_if bus();

  sample_block_writer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    bus.BLK_DONE = 1'b1;
    tick();
    bus.BLK_DONE = 1'b0;
  endtask

  // Starts in cycle 0 (match asserted now) and returns in cycle 84.
  task automatic run_block(input logic [23:0] num, input int drop_at, input int jtag_at,
                           input bit done_pulse);
    int c;
    bus.L1A_NUM   = num;
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
    check("hdr1", {19'd0, bus.L1A_WR_EN, bus.L1A_WDATA}, {19'd0, 1'b1, num[11:0]});
    tick();
    check("hdr2", {19'd0, bus.L1A_WR_EN, bus.L1A_WDATA}, {19'd0, 1'b1, num[23:12]});
    tick();
    c = 3;
    for (int ch = 0; ch < 16; ch++) begin
      for (int cp = 0; cp < 5; cp++) begin
        check($sformatf("write_c%0d", c),
              {22'd0, bus.OVFL, bus.L1A_WR_EN, bus.WREN, bus.CHIP, bus.CHAN},
              {22'd0, (c == drop_at + 1), 1'b0, 1'b1, 3'(cp), 4'(ch)});
        bus.L1A_MATCH = (c == drop_at);
        if (c == jtag_at) bus.JTAG_MODE = 1'b1;
        tick();
        c++;
      end
    end
    check("done_cycle", {29'd0, bus.WREN, bus.L1A_WR_EN, bus.OVFL}, 32'd0);
    bus.BLK_DONE = done_pulse;
    tick();
    bus.BLK_DONE = 1'b0;
    $display("block %h done drop_at=%0d jtag_at=%0d blk_done=%0d cnt=%0d",
             num, drop_at, jtag_at, done_pulse, bus.BLK_CNT);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.JTAG_MODE = 1'b0;
    bus.L1A_MATCH = 1'b0;
    bus.L1A_NUM   = 24'd0;
    bus.BLK_DONE  = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {6'd0, bus.L1A_WR_EN, bus.L1A_WDATA, bus.WREN, bus.CHIP, bus.CHAN,
           bus.RDY, bus.OVFL, bus.BLK_CNT}, 32'd0);
    rst = 1'b0;
    tick();

    // Single block
    check("pre_rdy", {28'd0, bus.RDY, bus.BLK_CNT}, 32'd0);
    run_block(24'hABC123, -1, -1, 1'b0);
    check("single_cnt", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd1});

    // Back-to-back match in cycle 84, busy drop in cycle 50
    run_block(24'h456789, 50, -1, 1'b0);
    check("b2b_cnt", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd2});

    // Fill to capacity, then the fifth match is dropped
    run_block(24'h0F0E0D, -1, -1, 1'b0);
    check("cnt3", {29'd0, bus.BLK_CNT}, 32'd3);
    run_block(24'h123456, -1, -1, 1'b0);
    check("cnt4", {29'd0, bus.BLK_CNT}, 32'd4);
    bus.L1A_NUM   = 24'hFFFFFF;
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
    check("full_ovfl", {30'd0, bus.OVFL, bus.L1A_WR_EN}, 32'd2);
    tick();
    check("full_nowrite", {27'd0, bus.OVFL, bus.L1A_WR_EN, bus.BLK_CNT}, 32'd4);
    tick();
    check("full_idle", {30'd0, bus.L1A_WR_EN, bus.WREN}, 32'd0);
    $display("full drop cnt=%0d", bus.BLK_CNT);

    // Consumption, and consumption coinciding with Done
    pulse_done();
    check("dec_cnt", {29'd0, bus.BLK_CNT}, 32'd3);
    run_block(24'h00A5A5, -1, -1, 1'b1);
    check("simul_cnt", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd3});
    pulse_done();
    pulse_done();
    check("dec_cnt1", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd1});
    pulse_done();
    check("dec_cnt0", {28'd0, bus.RDY, bus.BLK_CNT}, 32'd0);
    pulse_done();
    check("underflow", {28'd0, bus.RDY, bus.BLK_CNT}, 32'd0);
    $display("drain cnt=%0d rdy=%0d", bus.BLK_CNT, bus.RDY);

    // JTAG_MODE drop, then JTAG_MODE raised mid-block
    bus.JTAG_MODE = 1'b1;
    bus.L1A_NUM   = 24'h777777;
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
    check("jtag_ovfl", {30'd0, bus.OVFL, bus.L1A_WR_EN}, 32'd2);
    tick();
    check("jtag_nowrite", {29'd0, bus.OVFL, bus.L1A_WR_EN, bus.WREN}, 32'd0);
    bus.JTAG_MODE = 1'b0;
    tick();
    run_block(24'h321CBA, -1, 20, 1'b0);
    check("jtag_mid_cnt", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd1});
    bus.JTAG_MODE = 1'b0;
    tick();

    // Reset in cycle 40 of a block
    bus.L1A_NUM   = 24'h55AA33;
    bus.L1A_MATCH = 1'b1;
    tick();
    bus.L1A_MATCH = 1'b0;
    for (int i = 1; i < 40; i++) tick();
    check("pre_reset_wren", {31'd0, bus.WREN}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset",
          {6'd0, bus.L1A_WR_EN, bus.L1A_WDATA, bus.WREN, bus.CHIP, bus.CHAN,
           bus.RDY, bus.OVFL, bus.BLK_CNT}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_block(24'h000FFF, -1, -1, 1'b0);
    check("post_reset_cnt", {28'd0, bus.RDY, bus.BLK_CNT}, {28'd0, 1'b1, 3'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_block_writer.md
# sample_block_writer

Write-side controller for the DCFEB sample buffers and the producer end of the readout handshake. On each accepted L1A match it writes a two-word L1A header into the L1A FIFO and one 5-chip × 16-channel block of samples into the sample FIFO, then holds `RDY` high while at least one complete block is buffered. The downstream transfer sequencer consumes blocks and returns `BLK_DONE`.

## Interface
- `NCHIP`, default 5: chips per block. Chip index runs 0..NCHIP-1.
- `NCHAN`, default 16: channels per chip. Channel index runs 0..NCHAN-1.
- `MAX_BLK`, default 4: buffer capacity in complete blocks.
- `CLK` input, 1 bit: single clock. All logic is on the rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `JTAG_MODE` input, 1 bit: when high, new L1A matches are not accepted.
- `L1A_MATCH` input, 1 bit: one-cycle pulse requesting a block capture.
- `L1A_NUM` input, 24 bits: L1A number, sampled in the cycle `L1A_MATCH` is accepted.
- `BLK_DONE` input, 1 bit: one-cycle pulse from the reader, meaning one block has been consumed.
- `L1A_WR_EN` output, 1 bit: L1A FIFO write enable.
- `L1A_WDATA` output, 12 bits: L1A FIFO write data.
- `WREN` output, 1 bit: sample FIFO write enable.
- `CHIP` output, 3 bits: chip select for the upstream ADC data mux.
- `CHAN` output, 4 bits: channel select for the upstream ADC data mux.
- `RDY` output, 1 bit: high while the block count is non-zero.
- `OVFL` output, 1 bit: one-cycle pulse when a match is dropped.
- `BLK_CNT` output, 3 bits: number of complete blocks buffered.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state register resets to Idle.
- **Idle**
  - If `L1A_MATCH` is high, `JTAG_MODE` is low and `BLK_CNT < MAX_BLK`: capture `L1A_NUM`, go to Hdr1.
  - If `L1A_MATCH` is high but `JTAG_MODE` is high or the buffer is full: pulse `OVFL` and stay in Idle.
- **Hdr1**: `L1A_WR_EN`=1, `L1A_WDATA`=captured bits [11:0]. Go to Hdr2.
- **Hdr2**: `L1A_WR_EN`=1, `L1A_WDATA`=captured bits [23:12]. Clear `CHIP` and `CHAN`. Go to Write.
- **Write**
  - `WREN`=1 every cycle.
  - Word order: chip is the inner index and channel the outer index. This matches the reader's `CHIP`/`CHAN` increment order.
  - `CHIP` increments each cycle. When `CHIP`=NCHIP-1, `CHIP` wraps to 0 and `CHAN` increments.
  - When `CHIP`=NCHIP-1 and `CHAN`=NCHAN-1, that is the last write; go to Done.
- **Done**: increment the block count. Go to Idle.
- Block count update on each edge:
  - Done without `BLK_DONE`: +1.
  - `BLK_DONE` without Done: -1.
  - Both in the same cycle: unchanged.
  - `BLK_DONE` while the count is 0: ignored, no underflow.
- The count is never incremented above `MAX_BLK`; this is guaranteed by the acceptance check in Idle.
- `L1A_MATCH` in any state other than Idle: dropped and `OVFL` pulsed. There is no pending latch.
- `JTAG_MODE` rising mid-block does not abort the block; the block completes normally.
- Reset mid-block: the partial block is abandoned and the count returns to 0. The FIFOs are reset externally by the same `RST`.

## Timing
- Cycle 0 is the cycle in which `L1A_MATCH` is accepted.
- `L1A_WR_EN` is high in cycles 1–2.
- `WREN` is high in cycles 3 to 2+NCHIP·NCHAN, which is cycles 3–82 at defaults.
- Done is cycle 83. `BLK_CNT`/`RDY` update on the edge ending cycle 83, so they are visible from cycle 84.
- Idle is re-entered in cycle 84. A match in cycle 84 is accepted; a match in cycles 1–83 is dropped.
- `CHIP`/`CHAN` are valid in the same cycle as `WREN`. The upstream mux has zero latency and the FIFO writes on the same edge.
- `OVFL` is high in the cycle after the offending match.

## Structure
- A shared package `dcfeb_readout_pkg` holds:
  - constants `NCHIP`, `NCHAN` and the sample and L1A word widths (12);
  - the state encoding Idle/Hdr1/Hdr2/Write/Done, also used by the reader's documentation.
- A single sub-module, `blk_counter`, implements the up/down block counter with saturation guard. It provides `BLK_CNT` and `RDY`.

## Test plan
- **Single block:** `L1A_NUM`=0xABC123 matched once. Expect:
  - `L1A_WDATA`=0x123 then 0xABC;
  - 80 `WREN` cycles with (`CHIP`,`CHAN`) sequence (0,0),(1,0)…(4,0),(0,1)…(4,15);
  - `RDY` rises in cycle 84, `BLK_CNT`=1.
- **Back-to-back and busy drop:** matches in cycle 0 and cycle 84. Both are accepted and `BLK_CNT`=2. A match in cycle 50 gives an `OVFL` pulse and no extra writes.
- **Full:** five matches with no `BLK_DONE`. The fifth gives `OVFL`=1 and no `L1A_WR_EN`; `BLK_CNT` stays 4.
- **Simultaneous events:** `BLK_DONE` in a Done cycle leaves `BLK_CNT` unchanged. `BLK_DONE` at count 0 leaves `BLK_CNT`=0 and `RDY`=0.
- **JTAG_MODE:** a match with `JTAG_MODE`=1 gives `OVFL` and no writes. `JTAG_MODE` raised in cycle 20 of a block still produces all 80 writes and `BLK_CNT`=1.
- **Reset mid-block:** `RST` pulsed in cycle 40. All outputs go to 0 immediately, the block is not counted, and the next match runs a full block from (0,0).
